// File: rtl/aes_key_unexpand.sv
// Reverse AES-128 key schedule. Takes the round-10 key and walks the schedule
// backwards, presenting round keys 10 down to 0 on a valid/ready stream, one per
// accepted beat. Only the current round key is stored.
module aes_key_unexpand #(
    parameter int unsigned NROUNDS = 10
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         key_valid,
    output logic         key_ready,
    input  logic [127:0] key_in,
    output logic         rk_valid,
    input  logic         rk_ready,
    output logic [127:0] rk_out,
    output logic [3:0]   rk_idx,
    output logic         rk_last,
    output logic         busy
);

    // Only the AES-128 schedule (10 rounds) is implemented.
    if (NROUNDS != 10) begin : g_bad_nrounds
        $error("aes_key_unexpand: only NROUNDS = 10 is supported");
    end

    typedef enum logic {
        st_idle,
        st_run
    } state_t;

    state_t         state_q, state_d;
    logic [127:0]   rk_q, rk_d;
    logic [3:0]     idx_q, idx_d;
    logic [127:0]   rk_prev;
    logic [7:0]     rcon;

    // GF(2^8) multiply modulo x^8 + x^4 + x^3 + x + 1.
    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] aa;
        p  = 8'h00;
        aa = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) begin
                p = p ^ aa;
            end
            aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    // Forward S-box: multiplicative inverse (x^254, which maps 0 to 0) then affine map.
    function automatic logic [7:0] sbox(input logic [7:0] x);
        logic [7:0] sq;
        logic [7:0] inv;
        sq  = x;
        inv = 8'h01;
        for (int i = 1; i < 8; i++) begin
            sq  = gf_mul(sq, sq);
            inv = gf_mul(inv, sq);
        end
        return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
               {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [31:0] subword(input logic [31:0] w);
        return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
    endfunction

    // Round constant used to derive round idx_q from round idx_q - 1.
    always_comb begin
        rcon = 8'h00;
        unique case (idx_q)
            4'd1:    rcon = 8'h01;
            4'd2:    rcon = 8'h02;
            4'd3:    rcon = 8'h04;
            4'd4:    rcon = 8'h08;
            4'd5:    rcon = 8'h10;
            4'd6:    rcon = 8'h20;
            4'd7:    rcon = 8'h40;
            4'd8:    rcon = 8'h80;
            4'd9:    rcon = 8'h1b;
            4'd10:   rcon = 8'h36;
            default: rcon = 8'h00;
        endcase
    end

    // Previous round key; the recovered w3 feeds SubWord(RotWord()) for w0.
    always_comb begin
        logic [31:0] w0, w1, w2, w3;
        logic [31:0] p0, p1, p2, p3;
        w0 = rk_q[127:96];
        w1 = rk_q[95:64];
        w2 = rk_q[63:32];
        w3 = rk_q[31:0];
        p3 = w3 ^ w2;
        p2 = w2 ^ w1;
        p1 = w1 ^ w0;
        p0 = w0 ^ subword({p3[23:0], p3[31:24]}) ^ {rcon, 24'h000000};
        rk_prev = {p0, p1, p2, p3};
    end

    // Next-state: load on key handshake, step back one round per output handshake.
    always_comb begin
        state_d = state_q;
        rk_d    = rk_q;
        idx_d   = idx_q;
        unique case (state_q)
            st_idle: begin
                if (key_valid) begin
                    rk_d    = key_in;
                    idx_d   = 4'd10;
                    state_d = st_run;
                end
            end
            st_run: begin
                if (rk_ready) begin
                    if (idx_q == 4'd0) begin
                        state_d = st_idle;
                    end else begin
                        rk_d  = rk_prev;
                        idx_d = idx_q - 4'd1;
                    end
                end
            end
            default: state_d = st_idle;
        endcase
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= st_idle;
            rk_q    <= '0;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            rk_q    <= rk_d;
            idx_q   <= idx_d;
        end
    end

    // Outputs decoded from state.
    always_comb begin
        key_ready = (state_q == st_idle);
        rk_valid  = (state_q == st_run);
        busy      = (state_q == st_run);
        rk_out    = rk_q;
        rk_idx    = idx_q;
        rk_last   = (state_q == st_run) && (idx_q == 4'd0);
    end

endmodule

// File: tb/tb_aes_key_unexpand.sv
// Bench for aes_key_unexpand: forward key-expansion model feeds a scoreboard of
// expected round keys which is drained as the DUT emits beats.
module tb_aes_key_unexpand;

    logic         clk;
    logic         rst_n;
    logic         key_valid;
    logic         key_ready;
    logic [127:0] key_in;
    logic         rk_valid;
    logic         rk_ready;
    logic [127:0] rk_out;
    logic [3:0]   rk_idx;
    logic         rk_last;
    logic         busy;

    aes_key_unexpand #(.NROUNDS(10)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .key_valid (key_valid),
        .key_ready (key_ready),
        .key_in    (key_in),
        .rk_valid  (rk_valid),
        .rk_ready  (rk_ready),
        .rk_out    (rk_out),
        .rk_idx    (rk_idx),
        .rk_last   (rk_last),
        .busy      (busy)
    );

    localparam logic [127:0] FIPS_KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;

    localparam logic [2047:0] SBOX_TBL = {
        128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
    };

    typedef struct {
        logic [3:0]   idx;
        logic [127:0] rk;
    } exp_t;

    exp_t         sb_q[$];
    logic [127:0] ref_rk [0:10];
    logic [127:0] cap [0:10];
    logic         cap_last [0:10];
    int           beat_cyc [0:10];
    int           n_checks = 0;
    int           n_errors = 0;
    int           cyc = 0;
    int           acc_cyc = 0;
    int           acc_count = 0;
    int           last_done_cyc = 0;
    bit           rand_mode = 0;
    bit           prev_stall = 0;
    bit           last_pend = 0;
    logic [127:0] prev_rk;
    logic [3:0]   prev_idx;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic logic [7:0] tb_sbox(input logic [7:0] b);
        logic [2047:0] t;
        t = SBOX_TBL;
        return t[2047 - 8 * int'(b) -: 8];
    endfunction

    function automatic logic [31:0] tb_subword(input logic [31:0] w);
        return {tb_sbox(w[31:24]), tb_sbox(w[23:16]), tb_sbox(w[15:8]), tb_sbox(w[7:0])};
    endfunction

    function automatic logic [7:0] tb_rcon(input int r);
        logic [7:0] rc;
        rc = 8'h01;
        for (int i = 1; i < r; i++) begin
            rc = {rc[6:0], 1'b0} ^ (rc[7] ? 8'h1b : 8'h00);
        end
        return rc;
    endfunction

    // Forward AES-128 key expansion into ref_rk[0..10].
    task automatic expand_key(input logic [127:0] ck);
        logic [31:0] w [0:43];
        logic [31:0] t;
        w[0] = ck[127:96];
        w[1] = ck[95:64];
        w[2] = ck[63:32];
        w[3] = ck[31:0];
        for (int i = 4; i < 44; i++) begin
            t = w[i-1];
            if (i % 4 == 0) begin
                t = tb_subword({t[23:0], t[31:24]}) ^ {tb_rcon(i / 4), 24'h000000};
            end
            w[i] = w[i-4] ^ t;
        end
        for (int r = 0; r <= 10; r++) begin
            ref_rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
        end
    endtask

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc++;

    initial begin
        rk_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            rk_ready = rand_mode ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    // Monitor: push expectations on key handshake, pop and compare on output handshake.
    always @(negedge clk) begin
        exp_t e;
        if (!rst_n) begin
            prev_stall = 0;
            last_pend  = 0;
        end else begin
            if (last_pend) begin
                check("ready_after_last", 128'(key_ready), 128'(1));
                last_pend = 0;
            end
            if (prev_stall) begin
                check("stall_idx", 128'({rk_valid, rk_idx}), 128'({1'b1, prev_idx}));
                check("stall_rk", rk_out, prev_rk);
            end
            prev_stall = rk_valid && !rk_ready;
            prev_rk    = rk_out;
            prev_idx   = rk_idx;
            if (key_valid && key_ready) begin
                acc_cyc = cyc;
                acc_count++;
                for (int i = 10; i >= 0; i--) begin
                    e.idx = 4'(i);
                    e.rk  = ref_rk[i];
                    sb_q.push_back(e);
                end
            end
            if (rk_valid && rk_ready) begin
                if (sb_q.size() == 0) begin
                    check("extra_beat", 128'(rk_valid), 128'(0));
                end else begin
                    e = sb_q.pop_front();
                    check("rk_idx", 128'(rk_idx), 128'(e.idx));
                    check("rk_out", rk_out, e.rk);
                    check("rk_last", 128'(rk_last), 128'(e.idx == 4'd0));
                end
                if (rk_idx <= 4'd10) begin
                    cap[rk_idx]      = rk_out;
                    cap_last[rk_idx] = rk_last;
                    beat_cyc[rk_idx] = cyc;
                end
                if (rk_idx == 4'd0) begin
                    last_done_cyc = cyc;
                    last_pend     = 1;
                end
            end
        end
    end

    task automatic wait_accept(input int budget);
        int  start;
        bit  ok;
        start = acc_count;
        ok    = 0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            #1;
            if (acc_count != start) begin
                ok = 1;
                break;
            end
        end
        if (!ok) check("accept_timeout", 128'(acc_count - start), 128'(1));
    endtask

    task automatic wait_drain(input int budget);
        bit ok;
        ok = 0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            #1;
            if (sb_q.size() == 0 && key_ready) begin
                ok = 1;
                break;
            end
        end
        if (!ok) check("drain_timeout", 128'(sb_q.size()), 128'(0));
    endtask

    // Present the round-10 key of cipher key ck and release key_valid after acceptance.
    task automatic send_key(input logic [127:0] ck);
        expand_key(ck);
        @(posedge clk);
        #1;
        key_in    = ref_rk[10];
        key_valid = 1'b1;
        wait_accept(40);
        @(posedge clk);
        #1;
        key_valid = 1'b0;
        key_in    = {4{32'hdeadbeef}};
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [127:0] k1, k2;
        rst_n     = 1'b0;
        key_valid = 1'b0;
        key_in    = '0;

        // Reset state.
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_rk_valid", 128'(rk_valid), 128'(0));
        check("rst_rk_out", rk_out, 128'(0));
        check("rst_rk_idx", 128'(rk_idx), 128'(0));
        check("rst_rk_last", 128'(rk_last), 128'(0));
        check("rst_busy", 128'(busy), 128'(0));
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_key_ready", 128'(key_ready), 128'(1));

        // FIPS-197 A.1 with rk_ready held high.
        send_key(FIPS_KEY);
        wait_drain(40);
        check("fips_rk10", cap[10], 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
        check("fips_rk9", cap[9], 128'hac7766f319fadc2128d12941575c006e);
        check("fips_rk1", cap[1], 128'ha0fafe1788542cb123a339392a6c7605);
        check("fips_rk0", cap[0], FIPS_KEY);
        check("fips_last0", 128'(cap_last[0]), 128'(1));
        check("fips_first_lat", 128'(beat_cyc[10] - acc_cyc), 128'(1));
        check("fips_span", 128'(beat_cyc[0] - beat_cyc[10]), 128'(10));

        // Backpressure with pseudo-random rk_ready.
        rand_mode = 1;
        send_key(FIPS_KEY);
        wait_drain(400);
        rand_mode = 0;
        check("bp_rk0", cap[0], FIPS_KEY);

        // Busy rejection: an all-zero key offered during RUN must be ignored.
        expand_key(FIPS_KEY);
        @(posedge clk);
        #1;
        key_in    = ref_rk[10];
        key_valid = 1'b1;
        wait_accept(40);
        @(posedge clk);
        #1;
        key_in = '0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("busy_key_ready", 128'(key_ready), 128'(0));
            check("busy_flag", 128'(busy), 128'(1));
        end
        @(posedge clk);
        #1;
        k1 = {$urandom, $urandom, $urandom, $urandom};
        expand_key(k1);
        key_in = ref_rk[10];
        wait_accept(40);
        check("busy_accept_cyc", 128'(acc_cyc), 128'(last_done_cyc + 1));
        @(posedge clk);
        #1;
        key_valid = 1'b0;
        wait_drain(40);

        // Reset in the middle of a sequence, right after the idx-6 beat.
        send_key(FIPS_KEY);
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (rk_valid && rk_ready && rk_idx == 4'd6) break;
        end
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        sb_q.delete();
        @(negedge clk);
        check("mid_rst_rk_valid", 128'(rk_valid), 128'(0));
        check("mid_rst_rk_out", rk_out, 128'(0));
        check("mid_rst_busy", 128'(busy), 128'(0));
        check("mid_rst_key_ready", 128'(key_ready), 128'(1));
        send_key(FIPS_KEY);
        wait_drain(40);
        check("mid_rst_rk0", cap[0], FIPS_KEY);

        // Round-trip with random cipher keys.
        for (int n = 0; n < 100; n++) begin
            k1 = {$urandom, $urandom, $urandom, $urandom};
            send_key(k1);
            wait_drain(40);
            check("rt_rk0", cap[0], k1);
        end

        // Back-to-back keys with key_valid held high.
        k1 = {$urandom, $urandom, $urandom, $urandom};
        k2 = {$urandom, $urandom, $urandom, $urandom};
        expand_key(k1);
        @(posedge clk);
        #1;
        key_in    = ref_rk[10];
        key_valid = 1'b1;
        wait_accept(40);
        @(posedge clk);
        #1;
        expand_key(k2);
        key_in = ref_rk[10];
        wait_accept(40);
        check("b2b_accept_cyc", 128'(acc_cyc), 128'(last_done_cyc + 1));
        @(posedge clk);
        #1;
        key_valid = 1'b0;
        @(negedge clk);
        check("b2b_restart_idx", 128'(rk_idx), 128'(10));
        wait_drain(40);
        check("b2b_rk0", cap[0], k2);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/aes_key_unexpand.md
Name: aes_key_unexpand

Overview:
- Reverse AES-128 key schedule for the decryption datapath.
- Accepts the final round key (round 10) and regenerates round keys 10 down to 0, one per accepted output beat.
- The inverse cipher can consume keys in the order it needs them, with no 11x128-bit key store.
- Reuses the existing subword block (forward S-box) for the SubWord(RotWord()) term.

Parameters:
- NROUNDS, 10, number of rounds. Only 10 (AES-128) is supported; any other value is a configuration error.

Ports:
- clk  input  1  clock; all state updates on rising edge
- rst_n  input  1  synchronous active-low reset
- key_valid  input  1  key_in is valid
- key_ready  output  1  block can accept a new round-10 key (high only in IDLE)
- key_in  input  128  round-10 key; word0 = [127:96] ... word3 = [31:0]
- rk_valid  output  1  rk_out/rk_idx valid
- rk_ready  input  1  consumer accepts current round key
- rk_out  output  128  current round key, same word ordering as key_in
- rk_idx  output  4  round number of rk_out, 10 down to 0
- rk_last  output  1  high with rk_valid when rk_idx == 0
- busy  output  1  high in RUN state

Behaviour:
- Reset (rst_n low at a clock edge):
  - state = IDLE
  - rk_valid = 0, rk_out = 0, rk_idx = 0, rk_last = 0, busy = 0, key_ready = 1 after reset releases
  - Reset mid-run aborts the sequence immediately; no further beats are emitted.
- States:
  - IDLE: key_ready = 1, rk_valid = 0. On key_valid && key_ready, load rk_out = key_in and rk_idx = 10, go to RUN.
  - RUN: rk_valid = 1, key_ready = 0, key_valid ignored.
    - On rk_valid && rk_ready with rk_idx > 0: rk_out <= prev(rk_out, rk_idx), rk_idx <= rk_idx - 1.
    - On rk_valid && rk_ready with rk_idx == 0: go to IDLE, rk_valid <= 0.
    - With rk_ready low, rk_out and rk_idx hold stable (AXI-style, no drop, no change while stalled).
- Latency: first beat (idx 10) appears the cycle after key acceptance. With rk_ready held high, one beat per cycle: 11 beats in 11 consecutive cycles.
- key_ready rises the cycle after the idx-0 beat is accepted; no back-to-back overlap.
- prev(w0..w3, i) for i = 10..1:
  - p3 = w3 ^ w2; p2 = w2 ^ w1; p1 = w1 ^ w0
  - p0 = w0 ^ subword(rotword(p3)) ^ {rcon(i), 24'h0}
  - rotword(x) = {x[23:0], x[31:24]}
- rcon(i), i = 1..10: 01, 02, 04, 08, 10, 20, 40, 80, 1B, 36. Implement as a 4-bit-indexed constant case, or a GF(2^8) halving register starting at 36 (36 -> 1B -> 80 -> ... -> 01). Either way, index 10 must yield 36.
- The subword path is combinational from the rk_out register; no pipeline stage. Timing closure is at the single-cycle sbox depth.
- rk_last = rk_valid && (rk_idx == 0).
- key_in is sampled only on the handshake cycle; later changes have no effect.

Test Plan:
- FIPS-197 A.1: key_in = d014f9a8c9ee2589e13f0cc8b6630ca6, rk_ready = 1.
  - idx 10 = input
  - idx 9 = ac7766f319fadc2128d12941575c006e
  - idx 1 = a0fafe1788542cb123a339392a6c7605
  - idx 0 = 2b7e151628aed2a6abf7158809cf4f3c with rk_last = 1
  - 11 beats in 11 consecutive cycles, then key_ready = 1
- Backpressure:
  - Same key; toggle rk_ready pseudo-randomly.
  - rk_out/rk_idx stable whenever rk_valid && !rk_ready.
  - Identical 11-key sequence; no beat skipped or duplicated.
- Busy rejection:
  - Assert key_valid with key 00...0 during RUN.
  - key_ready = 0; ongoing sequence unchanged.
  - New key accepted only after idx 0 is consumed.
- Reset mid-run:
  - Drop rst_n for 1 cycle after the idx-6 beat.
  - Next cycle rk_valid = 0, rk_out = 0, busy = 0, key_ready = 1.
  - A fresh FIPS key then yields the full correct sequence.
- Round-trip:
  - 100 random 128-bit cipher keys expanded by a reference model to round 10, fed in.
  - Every idx-i output equals the model round key i, including idx 0 equal to the original key.
- Back-to-back:
  - Two keys presented with key_valid held high.
  - Second accepted exactly 1 cycle after the first sequence's idx-0 handshake.
  - rk_idx restarts at 10.
